// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply,
// optional restoring divider enabled by defining MULTICYCLE_ALU_DIV_EN.
module multicycle_alu #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FLAG_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            ALUCon,
    input  logic [WIDTH-1:0]      DataA,
    input  logic [WIDTH-1:0]      DataB,
    output logic                  ready,
    output logic                  done,
    output logic [WIDTH-1:0]      Result,
    output logic [FLAG_WIDTH-1:0] Flag
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned SHW = $clog2(WIDTH) + 1;
    localparam int unsigned CW  = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
`ifdef MULTICYCLE_ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b0101;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    logic [3:0]           op;
    logic                 opa_msb;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        cnt;

    logic [WIDTH-1:0]     alu_c;
    logic [SHW-1:0]       shamt_c;
    logic [WIDTH:0]       mul_sum_c;
    logic [FLAG_WIDTH-1:0] flag_c;

    // Single-cycle datapath, evaluated on the accept-edge operands
    always_comb begin
        shamt_c = DataB[SHW-1:0];
        alu_c   = '0;
        case (ALUCon)
            OP_AND: alu_c = DataA & DataB;
            OP_OR:  alu_c = DataA | DataB;
            OP_ADD: alu_c = DataA + DataB;
            OP_NOR: alu_c = ~(DataA | DataB);
            OP_SUB: alu_c = DataA - DataB;
            OP_SLT: alu_c = {{(WIDTH-1){1'b0}}, (DataA < DataB)};
            OP_SLL: alu_c = (shamt_c >= SHW'(WIDTH)) ? '0 : (DataA << shamt_c);
            OP_SRL: alu_c = (shamt_c >= SHW'(WIDTH)) ? '0 : (DataA >> shamt_c);
            default: alu_c = '0;
        endcase
    end

    // One shift-add step: low half holds the remaining multiplier bits
    always_comb begin
        mul_sum_c = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opb} : '0);
    end

`ifdef MULTICYCLE_ALU_DIV_EN
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   diff_c;

    // One restoring step: low half of prod shifts dividend out, quotient in
    always_comb begin
        rem_sh_c = {rem, prod[WIDTH-1]};
        diff_c   = rem_sh_c - {1'b0, opb};
    end
`endif

    // Flags derive from the already-registered raw result in DONE
    always_comb begin
        flag_c = '0;
        case (op)
            OP_ADD: begin
                if (opa_msb == opb[MSB] && prod[MSB] != opa_msb) begin
                    flag_c[1] = ~opa_msb;
                    flag_c[2] = opa_msb;
                end
            end
            OP_SUB: begin
                if (opa_msb != opb[MSB] && prod[MSB] != opa_msb) begin
                    flag_c[1] = ~opa_msb;
                    flag_c[2] = opa_msb;
                end
            end
            OP_MUL: flag_c[1] = |prod[2*WIDTH-1:WIDTH];
`ifdef MULTICYCLE_ALU_DIV_EN
            OP_DIV: flag_c[0] = (opb == '0);
`endif
            default: flag_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            Result  <= '0;
            Flag    <= '0;
            op      <= '0;
            opa_msb <= 1'b0;
            opb     <= '0;
            prod    <= '0;
            cnt     <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            rem     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op      <= ALUCon;
                        opa_msb <= DataA[MSB];
                        opb     <= DataB;
                        cnt     <= '0;
                        ready   <= 1'b0;
                        case (ALUCon)
                            OP_MUL: begin
                                prod  <= {{WIDTH{1'b0}}, DataA};
                                state <= MUL;
                            end
`ifdef MULTICYCLE_ALU_DIV_EN
                            OP_DIV: begin
                                rem <= '0;
                                if (DataB == '0) begin
                                    prod  <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                    state <= DONE;
                                end else begin
                                    prod  <= {{WIDTH{1'b0}}, DataA};
                                    state <= DIV;
                                end
                            end
`endif
                            default: begin
                                prod  <= {{WIDTH{1'b0}}, alu_c};
                                state <= DONE;
                            end
                        endcase
                    end
                end
                MUL: begin
                    prod <= {mul_sum_c, prod[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DIV: begin
`ifdef MULTICYCLE_ALU_DIV_EN
                    prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], ~diff_c[WIDTH]};
                    rem  <= diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
`else
                    state <= IDLE;
                    ready <= 1'b1;
`endif
                end
                DONE: begin
                    Result <= prod[WIDTH-1:0];
                    Flag   <= flag_c;
                    done   <= 1'b1;
                    ready  <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus randomized ops
// against an arithmetic reference model; honours MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;

    localparam int unsigned W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   ALUCon;
    logic [W-1:0] DataA;
    logic [W-1:0] DataB;
    logic         ready;
    logic         done;
    logic [W-1:0] Result;
    logic [2:0]   Flag;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_alu #(.WIDTH(W), .FLAG_WIDTH(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ALUCon (ALUCon),
        .DataA  (DataA),
        .DataB  (DataB),
        .ready  (ready),
        .done   (done),
        .Result (Result),
        .Flag   (Flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands, latency in cycles from accept edge to done
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] f, output int lat);
        longint          s;
        longint unsigned p;
        logic [5:0]      sh;
        r   = '0;
        f   = '0;
        lat = 1;
        sh  = b[5:0];
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = 32'(s);
                if (s > SMAX) f = 3'b010;
                else if (s < SMIN) f = 3'b100;
            end
            4'h3: begin
                p    = 64'(a) * 64'(b);
                r    = p[31:0];
                f[1] = (p[63:32] != 32'd0);
                lat  = 33;
            end
            4'h4: r = ~(a | b);
`ifdef MULTICYCLE_ALU_DIV_EN
            4'h5: begin
                if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF;
                    f = 3'b001;
                end else begin
                    r   = a / b;
                    lat = 33;
                end
            end
`endif
            4'h6: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = 32'(s);
                if (s > SMAX) f = 3'b010;
                else if (s < SMIN) f = 3'b100;
            end
            4'h7: r = (a < b) ? 32'd1 : 32'd0;
            4'h8: r = (sh >= 6'd32) ? 32'd0 : (a << sh);
            4'h9: r = (sh >= 6'd32) ? 32'd0 : (a >> sh);
            default: r = '0;
        endcase
    endfunction

    // Issue one request; optionally scramble inputs and pulse start while busy
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] er;
        logic [2:0]  ef;
        int          elat;
        int          lat;
        bit          got;
        model(op, a, b, er, ef, elat);
        check_eq("ready_before_accept", 64'(ready), 64'd1);
        ALUCon = op;
        DataA  = a;
        DataB  = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        got   = 1'b0;
        for (int k = 1; k <= 80 && !got; k++) begin
            if (noise) begin
                start  = 1'($urandom);
                ALUCon = 4'($urandom);
                DataA  = $urandom;
                DataB  = $urandom;
            end
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                lat = k;
            end
        end
        start = 1'b0;
        check_eq($sformatf("latency op=%h a=%h b=%h", op, a, b), 64'(lat), 64'(elat));
        check_eq($sformatf("result op=%h a=%h b=%h", op, a, b), 64'(Result), 64'(er));
        check_eq($sformatf("flag op=%h a=%h b=%h", op, a, b), 64'(Flag), 64'(ef));
        @(posedge clk); #1;
        check_eq("done_single_pulse", 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int pulses;
        reset  = 1'b1;
        start  = 1'b0;
        ALUCon = '0;
        DataA  = '0;
        DataB  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("reset_ready", 64'(ready), 64'd1);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_result", 64'(Result), 64'd0);
        check_eq("reset_flag", 64'(Flag), 64'd0);

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        run_op(4'b0011, 32'h0001_0000, 32'h0001_0000, 1'b1);
        run_op(4'b0101, 32'd100, 32'd7, 1'b1);
        run_op(4'b0101, 32'd5, 32'd0, 1'b0);
        run_op(4'b1000, 32'd1, 32'd31, 1'b0);
        run_op(4'b1001, 32'hFFFF_FFFF, 32'd32, 1'b0);
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        run_op(4'b0011, 32'd12345, 32'd6789, 1'b0);

        // Abort a multiply with reset at its tenth cycle
        check_eq("ready_before_abort", 64'(ready), 64'd1);
        ALUCon = 4'b0011;
        DataA  = 32'hDEAD_BEEF;
        DataB  = 32'h0000_1234;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("busy_mid_mul", 64'(ready), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_ready", 64'(ready), 64'd1);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_result", 64'(Result), 64'd0);
        check_eq("abort_flag", 64'(Flag), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_eq("abort_no_done", 64'(pulses), 64'd0);

        // Reset wins over a simultaneous start
        run_op(4'b0001, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        reset  = 1'b1;
        start  = 1'b1;
        ALUCon = 4'b0010;
        DataA  = 32'd1;
        DataB  = 32'd2;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        check_eq("prio_ready", 64'(ready), 64'd1);
        check_eq("prio_result", 64'(Result), 64'd0);
        @(posedge clk); #1;
        check_eq("prio_no_done", 64'(done), 64'd0);

        for (int i = 0; i < 300; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal 8..64).
REQ-002 SHALL have parameter FLAG_WIDTH, default 3, giving the flag vector width {underflow, overflow, div_by_zero}; fixed at 3.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, a request that is accepted only when ready=1.
REQ-006 SHALL have port ALUCon, input, 4 bits, the opcode sampled on acceptance.
REQ-007 SHALL have ports DataA and DataB, inputs, WIDTH bits each, the operands sampled on acceptance.
REQ-008 SHALL have port ready, output, 1 bit, high when idle and able to accept a request.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle pulse marking Result and Flag updated.
REQ-010 SHALL have port Result, output, WIDTH bits, registered and held until the next done.
REQ-011 SHALL have port Flag, output, 3 bits, registered and held until the next done.

Function
REQ-012 SHALL decode ALUCon as: 0000 and; 0001 or; 0010 add; 0011 mul; 0100 nor; 0101 div; 0110 sub; 0111 slt (unsigned, result 1/0); 1000 sll; 1001 srl.
REQ-013 SHALL treat all other opcodes as illegal: Result=0 and Flag=000 with single-cycle latency.
REQ-014 SHALL implement an FSM with states IDLE, MUL, DIV and DONE, where ready=1 only in IDLE.
REQ-015 SHALL transition IDLE to DONE on acceptance of single-cycle ops, so done asserts exactly 1 cycle after the accept edge.
REQ-016 SHALL implement mul as an iterative shift-add held in MUL for WIDTH cycles, with done WIDTH+1 cycles after acceptance and Result equal to the low WIDTH bits of the unsigned product.
REQ-017 SHALL set Flag[1] on mul when the upper WIDTH bits of the 2*WIDTH product are non-zero.
REQ-018 SHALL set Flag[1] on add/sub for positive signed overflow (two's-complement result wrongly negative) and Flag[2] for negative signed overflow (result wrongly non-negative).
REQ-019 SHALL compute Flag for add/sub from the registered result, not the previous value.
REQ-020 SHALL shift sll/srl by DataB[clog2(WIDTH):0], giving Result=0 for any shift amount >= WIDTH.
REQ-021 SHALL transition DONE to IDLE unconditionally after one cycle, so back-to-back requests are spaced by at least 2 cycles.
REQ-022 SHALL ignore start while ready=0, without queuing or corrupting the in-flight operation.
REQ-023 SHALL take operands only from the accept-edge sample, so DataA/DataB/ALUCon changes mid-operation have no effect.
REQ-024 SHALL clear all Flag bits to 0 for ops that do not define them.

Reset
REQ-025 SHALL on reset force state IDLE, ready=1, done=0, Result=0, Flag=000 and clear internal iteration counters.
REQ-026 SHALL let reset asserted mid-MUL or mid-DIV abort the operation with no done pulse.
REQ-027 SHALL give reset priority over a simultaneous start.

Configuration
REQ-028 SHALL, with macro MULTICYCLE_ALU_DIV_EN defined, implement div as unsigned restoring division in DIV for WIDTH cycles with Result=quotient and done WIDTH+1 cycles after acceptance.
REQ-029 SHALL, with MULTICYCLE_ALU_DIV_EN defined and DataB=0, skip DIV and complete in 1 cycle with Result all ones and Flag[0]=1.
REQ-030 SHALL, without MULTICYCLE_ALU_DIV_EN, synthesise no divider and handle opcode 0101 as illegal per REQ-013.

Verification
REQ-031 SHALL cover: WIDTH=32, add 0x7FFFFFFF+1 -> done 1 cycle later, Result 0x80000000, Flag 010.
REQ-032 SHALL cover: sub 0x80000000-1 -> Result 0x7FFFFFFF, Flag 100; then and 0xF0F0F0F0 & 0xFF00FF00 -> Result 0xF000F000, Flag 000.
REQ-033 SHALL cover: mul 0x10000*0x10000 -> done exactly 33 cycles after accept, Result 0, Flag 010, with start pulses during busy ignored.
REQ-034 SHALL cover, with DIV_EN: div 100/7 -> Result 14 after 33 cycles; div 5/0 -> Result 0xFFFFFFFF, Flag 001 after 1 cycle.
REQ-035 SHALL cover: sll 1 by 31 -> 0x80000000; srl 0xFFFFFFFF by 32 -> 0; opcode 1111 -> Result 0, Flag 000.
REQ-036 SHALL cover: reset asserted at cycle 10 of a mul -> no done pulse, ready=1 next cycle, Result 0.
